// File: rtl/sprite_compositor_pkg.sv
// Shared types and constants for the sprite compositor: FSM state encoding,
// default colour key and colour field widths.
package sprite_compositor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAYING = 3'd1,
    ST_FLASH   = 3'd2,
    ST_OVER    = 3'd3
  } state_t;

  localparam int DEF_COLOR_W = 12;
  localparam logic [DEF_COLOR_W-1:0] DEF_TRANSPARENT = 12'h000;
  localparam int DEF_RED_W = DEF_COLOR_W / 3;

  // Colour channels split the pixel into three equal fields, red on top.
  function automatic int red_field_w(input int color_w);
    return color_w / 3;
  endfunction

endpackage

// File: rtl/sprite_compositor_layer_mux.sv
// Combinational layer selection (priority or OR blend) and per-layer
// collision detection against the player sprite.
module layer_priority_mux
  import sprite_compositor_pkg::*;
#(
  parameter int N_LAYERS = 16,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(DEF_TRANSPARENT)
) (
  input  logic                              i_mode,
  input  logic                              i_blank,
  input  logic [COLOR_W-1:0]                i_player,
  input  logic [N_LAYERS-1:0][COLOR_W-1:0]  i_layer_color,
  input  logic [N_LAYERS-1:0]               i_layer_en,
  output logic [COLOR_W-1:0]                o_color,
  output logic [N_LAYERS-1:0]               o_hit
);

  logic [N_LAYERS-1:0] w_opaque;
  logic [COLOR_W-1:0]  w_prio;
  logic [COLOR_W-1:0]  w_or;
  logic                w_any_en;

  always_comb begin
    w_opaque = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      w_opaque[i] = i_layer_en[i] && (i_layer_color[i] != TRANSPARENT);
    end
  end

  // Scanning from the top index down lets the lowest index win.
  always_comb begin
    w_prio = TRANSPARENT;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (w_opaque[i]) w_prio = i_layer_color[i];
    end
  end

  always_comb begin
    w_or     = '0;
    w_any_en = 1'b0;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (i_layer_en[i]) begin
        w_or     = w_or | i_layer_color[i];
        w_any_en = 1'b1;
      end
    end
  end

  assign o_color = i_mode ? (w_any_en ? w_or : TRANSPARENT) : w_prio;
  assign o_hit   = (!i_blank && (i_player != TRANSPARENT)) ? w_opaque : '0;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor with per-frame collision accumulation and a
// small game-state FSM that tints the screen red after a hit.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int N_LAYERS = 16,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(DEF_TRANSPARENT),
  parameter int FLASH_FRAMES = 30,
  parameter int CNT_W = 8
) (
  input  logic                              pixel_clk,
  input  logic                              rst,
  input  logic                              hs_in,
  input  logic                              vs_in,
  input  logic                              blank_in,
  input  logic                              start,
  input  logic                              mode,
  input  logic [COLOR_W-1:0]                player_color,
  input  logic [N_LAYERS-1:0][COLOR_W-1:0]  layer_color,
  input  logic [N_LAYERS-1:0]               layer_en,
  input  logic [COLOR_W-1:0]                background,
  output logic [COLOR_W-1:0]                rgb_out,
  output logic                              hs_out,
  output logic                              vs_out,
  output logic                              enemy_run,
  output logic [N_LAYERS-1:0]               hit_mask,
  output logic [CNT_W-1:0]                  hit_frames,
  output logic [2:0]                        state_out
);

  localparam int RED_W = red_field_w(COLOR_W);
  localparam logic [COLOR_W-1:0] RED_MASK = ~({COLOR_W{1'b1}} >> RED_W);
  localparam int FC_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [FC_W-1:0] FLASH_LOAD = FC_W'(FLASH_FRAMES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [FC_W-1:0]     r_flash_cnt;
  logic [FC_W-1:0]     w_flash_next;
  logic                r_start_q;

  logic [COLOR_W-1:0]  r_layer_s1;
  logic [COLOR_W-1:0]  r_player_s1;
  logic [COLOR_W-1:0]  r_bg_s1;
  logic                r_hs_s1;
  logic                r_vs_s1;
  logic                r_blank_s1;
  logic [COLOR_W-1:0]  r_rgb;
  logic                r_hs_s2;
  logic                r_vs_s2;

  logic [N_LAYERS-1:0] r_acc;
  logic [N_LAYERS-1:0] r_hit_mask;
  logic [CNT_W-1:0]    r_hit_frames;

  logic [COLOR_W-1:0]  w_layer_color;
  logic [N_LAYERS-1:0] w_hit;
  logic                w_frame_edge;
  logic                w_start_rise;
  logic [COLOR_W-1:0]  w_pick;
  logic [COLOR_W-1:0]  w_tinted;

  layer_priority_mux #(
    .N_LAYERS    (N_LAYERS),
    .COLOR_W     (COLOR_W),
    .TRANSPARENT (TRANSPARENT)
  ) u_layer_mux (
    .i_mode        (mode),
    .i_blank       (blank_in),
    .i_player      (player_color),
    .i_layer_color (layer_color),
    .i_layer_en    (layer_en),
    .o_color       (w_layer_color),
    .o_hit         (w_hit)
  );

  assign w_frame_edge = r_vs_s1 & ~vs_in;
  assign w_start_rise = start & ~r_start_q;

  assign w_pick = (r_player_s1 != TRANSPARENT) ? r_player_s1 :
                  (r_layer_s1 != TRANSPARENT)  ? r_layer_s1  : r_bg_s1;
  assign w_tinted = ((r_state == ST_FLASH) || (r_state == ST_OVER)) ? (w_pick | RED_MASK) : w_pick;

  // Syncs idle high so that hs/vs look inactive straight out of reset.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_layer_s1  <= '0;
      r_player_s1 <= '0;
      r_bg_s1     <= '0;
      r_hs_s1     <= 1'b1;
      r_vs_s1     <= 1'b1;
      r_blank_s1  <= 1'b0;
      r_rgb       <= '0;
      r_hs_s2     <= 1'b1;
      r_vs_s2     <= 1'b1;
    end else begin
      r_layer_s1  <= w_layer_color;
      r_player_s1 <= player_color;
      r_bg_s1     <= background;
      r_hs_s1     <= hs_in;
      r_vs_s1     <= vs_in;
      r_blank_s1  <= blank_in;
      r_rgb       <= r_blank_s1 ? '0 : w_tinted;
      r_hs_s2     <= r_hs_s1;
      r_vs_s2     <= r_vs_s1;
    end
  end

  // The boundary cycle's own collisions seed the new frame so none are lost.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_hit_mask   <= '0;
      r_hit_frames <= '0;
    end else if (w_frame_edge) begin
      r_hit_mask <= r_acc;
      r_acc      <= w_hit;
      if ((r_acc != '0) && (r_hit_frames != '1)) r_hit_frames <= r_hit_frames + CNT_W'(1);
    end else begin
      r_acc <= r_acc | w_hit;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flash_cnt <= '0;
      r_start_q   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flash_cnt <= w_flash_next;
      r_start_q   <= start;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_flash_next = r_flash_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (w_frame_edge && (r_acc != '0)) begin
          w_state_next = ST_FLASH;
          w_flash_next = FLASH_LOAD;
        end
      end
      ST_FLASH: begin
        if (w_frame_edge) begin
          if (r_flash_cnt == '0) w_state_next = ST_OVER;
          else w_flash_next = r_flash_cnt - FC_W'(1);
        end
      end
      ST_OVER: begin
        if (w_start_rise) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rgb_out    = r_rgb;
  assign hs_out     = r_hs_s2;
  assign vs_out     = r_vs_s2;
  assign enemy_run  = (r_state == ST_PLAYING);
  assign hit_mask   = r_hit_mask;
  assign hit_frames = r_hit_frames;
  assign state_out  = r_state;

endmodule
